prog_sequencer: RTL and testbench



---
 rtl/prog_sequencer_pkg.sv | 25 ++
 rtl/prog_sequencer_if.sv | 32 +++
 rtl/prog_sequencer_pc.sv | 24 ++
 rtl/prog_sequencer.sv | 129 ++++++++++++
 tb/tb_prog_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: FSM states, decoder mode
// encodings and the per-program start address table.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } seq_state_t;

  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_TGT = 2'b01;
  localparam logic [1:0] MODE_IMM = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  localparam int ADDR_W = 9;

  localparam logic [ADDR_W-1:0] PROG_START [4] = '{9'd0, 9'd128, 9'd256, 9'd384};

  function automatic logic [ADDR_W-1:0] prog_start(input logic [1:0] sel);
    return PROG_START[sel];
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Sequencer <-> ROM/decoder/bench signal bundle. The master side drives run
// control and decoder results; the slave side is the sequencer itself.
interface prog_sequencer_if #(
  parameter int PC_W = 9
) ();
  logic            Start;
  logic [1:0]      ProgSel;
  logic [8:0]      Instruction;
  logic [1:0]      NextState;
  logic [8:0]      PrevInstructionOut;
  logic            BranchEn;
  logic [8:0]      BranchTarget;
  logic            Ack;
  logic [PC_W-1:0] ProgCtr;
  logic [1:0]      CurrState;
  logic [8:0]      PrevInstruction;
  logic            ExecEn;
  logic            Done;
  logic            Fault;

  modport master (
    output Start, ProgSel, Instruction, NextState, PrevInstructionOut,
           BranchEn, BranchTarget, Ack,
    input  ProgCtr, CurrState, PrevInstruction, ExecEn, Done, Fault
  );

  modport slave (
    input  Start, ProgSel, Instruction, NextState, PrevInstructionOut,
           BranchEn, BranchTarget, Ack,
    output ProgCtr, CurrState, PrevInstruction, ExecEn, Done, Fault
  );
endinterface

// File: rtl/prog_sequencer_pc.sv
// Program counter register: load has priority over increment, otherwise holds.
// at_top flags the last ROM address so the FSM can stop before wrapping.
module prog_counter #(
  parameter int PC_W = 9
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc,
  output logic            at_top
);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + PC_W'(1);
  end

  assign at_top = &pc;

endmodule

// File: rtl/prog_sequencer.sv
// Program-flow sequencer: owns PC, decoder mode and previous-instruction regs.
// Optional SEQ_CYCLE_COUNT_EN adds a saturating CycleCount of executed cycles.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int CTR_W = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  prog_sequencer_if.slave   bus
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [CTR_W-1:0]  CycleCount
`endif
);

  if (PC_W < ADDR_W) begin : g_pc_w_check
    $error("prog_sequencer: PC_W must be >= 9");
  end

  seq_state_t      state, state_nxt;
  logic            pc_load, pc_inc, at_top;
  logic [PC_W-1:0] pc_load_val, pc;
  logic            arm_clr, mode_upd, fault_set;
  logic            exec_en;
  logic [1:0]      mode;
  logic [8:0]      prev;
  logic            fault;

  prog_counter #(.PC_W(PC_W)) u_pc (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc),
    .at_top   (at_top)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.Start)  state_nxt = ARM;
      ARM:  if (!bus.Start) state_nxt = RUN;
      RUN: begin
        if (bus.Start)                     state_nxt = ARM;
        else if (bus.Ack)                  state_nxt = DONE;
        else if (!bus.BranchEn && at_top)  state_nxt = DONE;
      end
      DONE: if (bus.Start)  state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // RUN priority: restart, Ack, branch, end-of-ROM fault, increment.
  always_comb begin
    pc_load     = 1'b0;
    pc_load_val = '0;
    pc_inc      = 1'b0;
    arm_clr     = 1'b0;
    mode_upd    = 1'b0;
    fault_set   = 1'b0;
    unique case (state)
      ARM: begin
        pc_load     = 1'b1;
        pc_load_val = PC_W'(prog_start(bus.ProgSel));
        arm_clr     = 1'b1;
      end
      RUN: begin
        if (!bus.Start && !bus.Ack) begin
          if (bus.BranchEn) begin
            pc_load     = 1'b1;
            pc_load_val = PC_W'(bus.BranchTarget);
            mode_upd    = 1'b1;
          end else if (at_top) begin
            fault_set   = 1'b1;
          end else begin
            pc_inc      = 1'b1;
            mode_upd    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign exec_en = (state == RUN) && !bus.Start;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode  <= MODE_REG;
      prev  <= '0;
      fault <= 1'b0;
    end else if (arm_clr) begin
      mode  <= MODE_REG;
      prev  <= '0;
      fault <= 1'b0;
    end else begin
      if (mode_upd) begin
        mode <= bus.NextState;
        prev <= bus.PrevInstructionOut;
      end
      if (fault_set) fault <= 1'b1;
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                        CycleCount <= '0;
    else if (state == ARM)               CycleCount <= '0;
    else if (exec_en && !(&CycleCount))  CycleCount <= CycleCount + CTR_W'(1);
  end
`endif

  assign bus.ProgCtr         = pc;
  assign bus.CurrState       = mode;
  assign bus.PrevInstruction = prev;
  assign bus.ExecEn          = exec_en;
  assign bus.Done            = (state == DONE);
  assign bus.Fault           = fault;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: expected output snapshots are queued
// as stimulus is applied and compared once the DUT has responded.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  localparam int PC_W  = 9;
  localparam int CTR_W = 16;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  prog_sequencer_if #(.PC_W(PC_W)) bus ();
`ifdef SEQ_CYCLE_COUNT_EN
  logic [CTR_W-1:0] cycle_count;
`endif

  prog_sequencer #(.PC_W(PC_W), .CTR_W(CTR_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    .CycleCount (cycle_count)
`endif
  );

  typedef struct {
    string      tag;
    logic [8:0] pc;
    logic [1:0] mode;
    logic [8:0] prev;
    logic       exec;
    logic       done;
    logic       fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [8:0] pc, input logic [1:0] mode,
                      input logic [8:0] prev, input logic exec, input logic done,
                      input logic fault);
    exp_t e;
    e = '{tag, pc, mode, prev, exec, done, fault};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".pc"},    32'(bus.ProgCtr),         32'(e.pc));
      check({e.tag, ".mode"},  32'(bus.CurrState),       32'(e.mode));
      check({e.tag, ".prev"},  32'(bus.PrevInstruction), 32'(e.prev));
      check({e.tag, ".exec"},  32'(bus.ExecEn),          32'(e.exec));
      check({e.tag, ".done"},  32'(bus.Done),            32'(e.done));
      check({e.tag, ".fault"}, 32'(bus.Fault),           32'(e.fault));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expectation for the state after the next clock edge.
  task automatic step(input string tag, input logic [8:0] pc, input logic [1:0] mode,
                      input logic [8:0] prev, input logic exec, input logic done,
                      input logic fault);
    push(tag, pc, mode, prev, exec, done, fault);
    tick();
    drain();
  endtask

  // Expectation for the present cycle, without any clock edge.
  task automatic now_chk(input string tag, input logic [8:0] pc, input logic [1:0] mode,
                         input logic [8:0] prev, input logic exec, input logic done,
                         input logic fault);
    push(tag, pc, mode, prev, exec, done, fault);
    #1;
    drain();
  endtask

  task automatic set_in(input logic start, input logic [1:0] sel, input logic [1:0] ns,
                        input logic [8:0] pio, input logic ben, input logic [8:0] bt,
                        input logic ack);
    bus.Start              = start;
    bus.ProgSel            = sel;
    bus.Instruction        = 9'h000;
    bus.NextState          = ns;
    bus.PrevInstructionOut = pio;
    bus.BranchEn           = ben;
    bus.BranchTarget       = bt;
    bus.Ack                = ack;
  endtask

  // IDLE -> ARM (1 edge), ARM load with Start held (1 edge), ARM -> RUN (1 edge).
  task automatic launch(input logic [1:0] sel);
    logic [8:0] start_pc;
    start_pc = prog_start(sel);
    set_in(1'b1, sel, MODE_REG, 9'h000, 1'b0, 9'h000, 1'b0);
    tick();
    tick();
    bus.Start = 1'b0;
    step("launch", start_pc, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    set_in(1'b0, 2'd0, MODE_REG, 9'h000, 1'b0, 9'h000, 1'b0);
    #2;
    now_chk("reset", 9'h000, MODE_REG, 9'h000, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;

    // Asynchronous reset mid-run, then restart from program 2.
    launch(2'd0);
    repeat (68) tick();
    step("t1_run", 9'h045, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    now_chk("t1_async_rst", 9'h000, MODE_REG, 9'h000, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    launch(2'd2);

    // Target mode then branch.
    launch(2'd0);
    repeat (4) tick();
    step("t2_pc5", 9'h005, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 2'd0, MODE_TGT, 9'h033, 1'b0, 9'h000, 1'b0);
    step("t2_tgt_mode", 9'h006, MODE_TGT, 9'h033, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 2'd0, MODE_REG, 9'h044, 1'b1, 9'h020, 1'b0);
    step("t2_branch", 9'h020, MODE_REG, 9'h044, 1'b1, 1'b0, 1'b0);

    // Immediate mode and NOP pass-through.
    set_in(1'b0, 2'd0, MODE_REG, 9'h000, 1'b1, 9'h010, 1'b0);
    step("t3_br", 9'h010, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 2'd0, MODE_IMM, 9'h018, 1'b0, 9'h000, 1'b0);
    step("t3_imm", 9'h011, MODE_IMM, 9'h018, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 2'd0, MODE_NOP, 9'h019, 1'b0, 9'h000, 1'b0);
    step("t3_nop", 9'h012, MODE_NOP, 9'h019, 1'b1, 1'b0, 1'b0);

    // Ack outranks branch; DONE ignores decoder; restart from program 1.
    set_in(1'b0, 2'd1, MODE_REG, 9'h021, 1'b1, 9'h03A, 1'b0);
    step("t4_br", 9'h03A, MODE_REG, 9'h021, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 2'd1, MODE_TGT, 9'h0FF, 1'b1, 9'h100, 1'b1);
    now_chk("t4_ack_exec", 9'h03A, MODE_REG, 9'h021, 1'b1, 1'b0, 1'b0);
    step("t4_done", 9'h03A, MODE_REG, 9'h021, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 2'd1, MODE_IMM, 9'h0EE, 1'b1, 9'h150, 1'b1);
    step("t4_done_hold", 9'h03A, MODE_REG, 9'h021, 1'b0, 1'b1, 1'b0);
    set_in(1'b1, 2'd1, MODE_REG, 9'h000, 1'b0, 9'h000, 1'b0);
    now_chk("t4_start_in_done", 9'h03A, MODE_REG, 9'h021, 1'b0, 1'b1, 1'b0);
    step("t4_arm", 9'h03A, MODE_REG, 9'h021, 1'b0, 1'b0, 1'b0);
    bus.Start = 1'b0;
    step("t4_rerun", 9'h080, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);

    // Abort during RUN: ExecEn drops at once, PC holds, ARM reloads next edge.
    tick();
    bus.Start = 1'b1;
    now_chk("abort_exec", 9'h081, MODE_REG, 9'h000, 1'b0, 1'b0, 1'b0);
    step("abort_arm", 9'h081, MODE_REG, 9'h000, 1'b0, 1'b0, 1'b0);
    step("abort_load", 9'h080, MODE_REG, 9'h000, 1'b0, 1'b0, 1'b0);
    bus.Start = 1'b0;
    step("abort_rerun", 9'h080, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);

    // Branching to/from the top address is legal; incrementing past it faults.
    set_in(1'b0, 2'd1, MODE_REG, 9'h000, 1'b1, 9'h1FF, 1'b0);
    step("t5_br_top", 9'h1FF, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 2'd1, MODE_TGT, 9'h055, 1'b1, 9'h005, 1'b0);
    step("t5_br_from_top", 9'h005, MODE_TGT, 9'h055, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 2'd1, MODE_REG, 9'h000, 1'b1, 9'h1FF, 1'b0);
    step("t5_br_top2", 9'h1FF, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);
    set_in(1'b0, 2'd1, MODE_TGT, 9'h066, 1'b0, 9'h000, 1'b0);
    step("t5_fault", 9'h1FF, MODE_REG, 9'h000, 1'b0, 1'b1, 1'b1);
    step("t5_fault_hold", 9'h1FF, MODE_REG, 9'h000, 1'b0, 1'b1, 1'b1);
    set_in(1'b1, 2'd1, MODE_REG, 9'h000, 1'b0, 9'h000, 1'b0);
    step("t5_arm", 9'h1FF, MODE_REG, 9'h000, 1'b0, 1'b0, 1'b1);
    bus.Start = 1'b0;
    step("t5_rerun", 9'h080, MODE_REG, 9'h000, 1'b1, 1'b0, 1'b0);

`ifdef SEQ_CYCLE_COUNT_EN
    // Ten executed cycles, the last one carrying Ack.
    launch(2'd0);
    check("t6_cnt_start", 32'(cycle_count), 32'd0);
    repeat (9) tick();
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    check("t6_cnt_done", 32'(cycle_count), 32'd10);
    check("t6_done", 32'(bus.Done), 32'd1);
    repeat (3) tick();
    check("t6_cnt_hold", 32'(cycle_count), 32'd10);
    launch(2'd0);
    repeat (3) tick();
    bus.Start = 1'b1;
    now_chk("t6_abort_exec", 9'h003, MODE_REG, 9'h000, 1'b0, 1'b0, 1'b0);
    tick();
    check("t6_cnt_arm", 32'(cycle_count), 32'd3);
    tick();
    check("t6_cnt_clr", 32'(cycle_count), 32'd0);
    bus.Start = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
